// File: rtl/camera_capture_sequencer.sv
// camera_capture_sequencer
// Oversamples a camera port (pclk/hsync/vsync/data) in the system clock domain.
// On a start request it arms, waits for the next full frame and emits one
// region-of-interest window of that frame as single-cycle pixel strobes.
//
// Ports:
//   clk, reset                      system clock, async active-high reset
//   cam_pclk/hsync/vsync/data       camera pins, already synchronized to clk
//   start, cfg_left/width/top/height capture request and ROI window
//   busy, frame_done                capture in progress / completion pulse
//   short_frame, cfg_err            frame ended early / rejected config
//   pix_valid, pix_data, pix_x/y    ROI pixel strobe, data and ROI coordinates
//   line_end, frame_end             last ROI column / last ROI pixel markers
module camera_capture_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned XW     = 10,
    parameter int unsigned YW     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_pclk,
    input  logic              cam_hsync,
    input  logic              cam_vsync,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              start,
    input  logic [XW-1:0]     cfg_left,
    input  logic [XW-1:0]     cfg_width,
    input  logic [YW-1:0]     cfg_top,
    input  logic [YW-1:0]     cfg_height,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame,
    output logic              cfg_err,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y,
    output logic              line_end,
    output logic              frame_end
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_FRAME,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic              s1_pclk_q, s1_hs_q, s1_vs_q;
    logic              s2_pclk_q, s2_hs_q, s2_vs_q;
    logic [DATA_W-1:0] s1_data_q;

    logic [XW-1:0]     cx_q, cx_d;
    logic [YW-1:0]     cy_q, cy_d;

    logic [XW-1:0]     left_q, left_d, width_q, width_d;
    logic [YW-1:0]     top_q, top_d, height_q, height_d;

    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              short_frame_q, short_frame_d;
    logic              cfg_err_q, cfg_err_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic [XW-1:0]     pix_x_q, pix_x_d;
    logic [YW-1:0]     pix_y_q, pix_y_d;
    logic              line_end_q, line_end_d;
    logic              frame_end_q, frame_end_d;

    logic              pclk_rise, hs_fall, vs_rise, vs_fall, hs_active;
    logic [XW:0]       x_end;
    logic [YW:0]       y_end;
    logic              in_x, in_y, roi_hit;
    logic [XW-1:0]     rel_x;
    logic [YW-1:0]     rel_y;
    logic              hit_line_end, hit_frame_end;

    // Edge detection on the oversampled camera controls.
    always_comb begin
        pclk_rise = s1_pclk_q & ~s2_pclk_q;
        hs_fall   = ~s1_hs_q & s2_hs_q;
        vs_rise   = s1_vs_q & ~s2_vs_q;
        vs_fall   = ~s1_vs_q & s2_vs_q;
        // s2 keeps the line open for a pclk edge coinciding with hsync falling
        hs_active = s1_hs_q | s2_hs_q;
    end

    // Camera column/row counters, saturating.
    always_comb begin
        cx_d = cx_q;
        if (hs_fall || vs_rise) begin
            cx_d = '0;
        end else if (pclk_rise && s1_hs_q && (cx_q != '1)) begin
            cx_d = cx_q + XW'(1);
        end

        cy_d = cy_q;
        if (vs_rise) begin
            cy_d = '0;
        end else if (hs_fall && s1_vs_q && (cy_q != '1)) begin
            cy_d = cy_q + YW'(1);
        end
    end

    // ROI window decode; end bounds are one bit wider so they never wrap.
    always_comb begin
        x_end         = {1'b0, left_q} + {1'b0, width_q};
        y_end         = {1'b0, top_q} + {1'b0, height_q};
        in_x          = (cx_q >= left_q) && ({1'b0, cx_q} < x_end);
        in_y          = (cy_q >= top_q) && ({1'b0, cy_q} < y_end);
        roi_hit       = pclk_rise && hs_active && in_x && in_y;
        rel_x         = cx_q - left_q;
        rel_y         = cy_q - top_q;
        hit_line_end  = (rel_x == width_q - XW'(1));
        hit_frame_end = hit_line_end && (rel_y == height_q - YW'(1));
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        left_d        = left_q;
        width_d       = width_q;
        top_d         = top_q;
        height_d      = height_q;
        frame_done_d  = 1'b0;
        short_frame_d = short_frame_q;
        cfg_err_d     = cfg_err_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        line_end_d    = 1'b0;
        frame_end_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    left_d        = cfg_left;
                    width_d       = cfg_width;
                    top_d         = cfg_top;
                    height_d      = cfg_height;
                    short_frame_d = 1'b0;
                    cfg_err_d     = 1'b0;
                    if ((cfg_width == '0) || (cfg_height == '0)) begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d   = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                // never start inside a frame that is already running
                if (!s1_vs_q) begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (vs_rise) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (roi_hit) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = s1_data_q;
                    pix_x_d     = rel_x;
                    pix_y_d     = rel_y;
                    line_end_d  = hit_line_end;
                    frame_end_d = hit_frame_end;
                    if (hit_frame_end) begin
                        state_d = ST_DONE;
                    end
                end
                // the final pixel wins over a coincident end of frame
                if (vs_fall && !(roi_hit && hit_frame_end)) begin
                    short_frame_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, sampling stage, counters, shadow config and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            s1_pclk_q     <= 1'b0;
            s1_hs_q       <= 1'b0;
            s1_vs_q       <= 1'b0;
            s1_data_q     <= '0;
            s2_pclk_q     <= 1'b0;
            s2_hs_q       <= 1'b0;
            s2_vs_q       <= 1'b0;
            cx_q          <= '0;
            cy_q          <= '0;
            left_q        <= '0;
            width_q       <= '0;
            top_q         <= '0;
            height_q      <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_pclk_q     <= cam_pclk;
            s1_hs_q       <= cam_hsync;
            s1_vs_q       <= cam_vsync;
            s1_data_q     <= cam_data;
            s2_pclk_q     <= s1_pclk_q;
            s2_hs_q       <= s1_hs_q;
            s2_vs_q       <= s1_vs_q;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            left_q        <= left_d;
            width_q       <= width_d;
            top_q         <= top_d;
            height_q      <= height_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
            cfg_err_q     <= cfg_err_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_end_q    <= line_end_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;
    assign cfg_err     = cfg_err_q;
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_end    = line_end_q;
    assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// Self-checking bench for camera_capture_sequencer: a camera model drives
// frames, a reference ROI model pushes expected pixels into a queue, and a
// monitor pops and compares them as the DUT strobes pixels out.
module tb_camera_capture_sequencer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned XW     = 10;
    localparam int unsigned YW     = 9;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [XW-1:0]     x;
        logic [YW-1:0]     y;
        logic              le;
        logic              fe;
        int                cyc;
    } pix_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cam_pclk = 1'b0;
    logic              cam_hsync = 1'b0;
    logic              cam_vsync = 1'b0;
    logic [DATA_W-1:0] cam_data = '0;
    logic              start = 1'b0;
    logic [XW-1:0]     cfg_left = '0;
    logic [XW-1:0]     cfg_width = '0;
    logic [YW-1:0]     cfg_top = '0;
    logic [YW-1:0]     cfg_height = '0;
    logic              busy, frame_done, short_frame, cfg_err;
    logic              pix_valid, line_end, frame_end;
    logic [DATA_W-1:0] pix_data;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    pix_t exp_q[$];
    bit   exp_capture = 1'b0;
    bit   exp_short = 1'b0;
    int   exp_fd_cyc = -2;
    int   m_left, m_width, m_top, m_height;
    int   pix_count = 0;
    int   fd_count = 0;
    int   fd_cyc = -1;
    logic prev_valid = 1'b0;

    camera_capture_sequencer #(.DATA_W(DATA_W), .XW(XW), .YW(YW)) dut (
        .clk(clk), .reset(reset),
        .cam_pclk(cam_pclk), .cam_hsync(cam_hsync), .cam_vsync(cam_vsync), .cam_data(cam_data),
        .start(start), .cfg_left(cfg_left), .cfg_width(cfg_width), .cfg_top(cfg_top), .cfg_height(cfg_height),
        .busy(busy), .frame_done(frame_done), .short_frame(short_frame), .cfg_err(cfg_err),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .line_end(line_end), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the scoreboard on every pixel strobe.
    always @(negedge clk) begin
        pix_t m;
        if (!reset) begin
            if (pix_valid) begin
                pix_count++;
                n_cmp++;
                if (prev_valid) begin
                    n_fail++;
                    $display("FAIL pix_back_to_back: got pix_valid high two cycles at cycle %0d, required single-cycle", cyc);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pix_unexpected: got x=%0d y=%0d data=%0h at cycle %0d, required no pixel", pix_x, pix_y, pix_data, cyc);
                end else begin
                    m = exp_q.pop_front();
                    if (pix_data !== m.data || pix_x !== m.x || pix_y !== m.y ||
                        line_end !== m.le || frame_end !== m.fe || cyc != m.cyc) begin
                        n_fail++;
                        $display("FAIL pix_field: got data=%0h x=%0d y=%0d le=%0b fe=%0b cyc=%0d, required data=%0h x=%0d y=%0d le=%0b fe=%0b cyc=%0d",
                                 pix_data, pix_x, pix_y, line_end, frame_end, cyc, m.data, m.x, m.y, m.le, m.fe, m.cyc);
                    end
                end
            end
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
        end
        prev_valid = pix_valid;
    end

    task automatic set_cfg(input int l, input int w, input int t, input int h);
        m_left = l; m_width = w; m_top = t; m_height = h;
        cfg_left = XW'(l); cfg_width = XW'(w); cfg_top = YW'(t); cfg_height = YW'(h);
    endtask

    task automatic clear_track();
        pix_count = 0; fd_count = 0; fd_cyc = -1;
        exp_fd_cyc = -2; exp_short = 1'b0; exp_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy === 1'b1; i++) @(negedge clk);
    endtask

    // Camera model plus reference ROI model feeding the scoreboard.
    task automatic send_frame(input int cols, input int rows, input int seed);
        pix_t e;
        logic [DATA_W-1:0] d;
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (3) @(negedge clk);
        for (int r = 0; r < rows; r++) begin
            cam_hsync = 1'b1;
            repeat (2) @(negedge clk);
            for (int c = 0; c < cols; c++) begin
                d = DATA_W'((r * 16 + c + seed) & 255);
                cam_data = d;
                cam_pclk = 1'b1;
                if (exp_capture && c >= m_left && c < m_left + m_width &&
                    r >= m_top && r < m_top + m_height) begin
                    e.data = d;
                    e.x    = XW'(c - m_left);
                    e.y    = YW'(r - m_top);
                    e.le   = (c - m_left == m_width - 1);
                    e.fe   = e.le && (r - m_top == m_height - 1);
                    e.cyc  = cyc + 2;
                    exp_q.push_back(e);
                    if (e.fe) begin
                        exp_fd_cyc  = cyc + 3;
                        exp_capture = 1'b0;
                    end
                end
                repeat (2) @(negedge clk);
                cam_pclk = 1'b0;
                repeat (2) @(negedge clk);
            end
            cam_hsync = 1'b0;
            repeat (3) @(negedge clk);
        end
        cam_vsync = 1'b0;
        if (exp_capture) begin
            exp_short   = 1'b1;
            exp_fd_cyc  = cyc + 3;
            exp_capture = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, frame_done, short_frame, cfg_err, pix_valid, pix_data, pix_x, pix_y, line_end, frame_end} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b fd=%0b sf=%0b ce=%0b pv=%0b, required all 0", busy, frame_done, short_frame, cfg_err, pix_valid);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %0b, required 0", busy); end
    endtask

    task automatic test_basic_roi();
        clear_track();
        set_cfg(2, 4, 1, 3);
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b, required 1", busy); end
        // changing the inputs mid-capture must not disturb the shadowed window
        cfg_left = XW'(7); cfg_width = XW'(1); cfg_top = '0; cfg_height = YW'(1);
        exp_capture = 1'b1;
        send_frame(8, 6, 0);
        wait_idle();
        n_cmp++;
        if (pix_count !== 12) begin n_fail++; $display("FAIL basic_count: got %0d, required 12", pix_count); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_missing: got %0d pending, required 0", exp_q.size()); end
        n_cmp++;
        if (fd_count !== 1 || fd_cyc !== exp_fd_cyc) begin
            n_fail++; $display("FAIL basic_frame_done: got count=%0d cyc=%0d, required 1 at %0d", fd_count, fd_cyc, exp_fd_cyc);
        end
        n_cmp++;
        if (short_frame !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_status: got sf=%0b busy=%0b, required 0 0", short_frame, busy);
        end
    endtask

    task automatic test_midframe_start();
        clear_track();
        set_cfg(2, 4, 1, 3);
        exp_capture = 1'b0;
        fork
            send_frame(8, 6, 3);
            begin
                repeat (40) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        n_cmp++;
        if (pix_count !== 0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midframe_skip: got pixels=%0d busy=%0b, required 0 1", pix_count, busy);
        end
        exp_capture = 1'b1;
        send_frame(8, 6, 5);
        wait_idle();
        n_cmp++;
        if (pix_count !== 12 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL midframe_count: got %0d pending=%0d, required 12 0", pix_count, exp_q.size());
        end
        n_cmp++;
        if (fd_cyc !== exp_fd_cyc) begin n_fail++; $display("FAIL midframe_done: got %0d, required %0d", fd_cyc, exp_fd_cyc); end
    endtask

    task automatic test_short_frame();
        clear_track();
        set_cfg(2, 4, 2, 10);
        pulse_start();
        exp_capture = 1'b1;
        send_frame(8, 6, 11);
        wait_idle();
        n_cmp++;
        if (pix_count !== 16 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL short_count: got %0d pending=%0d, required 16 0", pix_count, exp_q.size());
        end
        n_cmp++;
        if (short_frame !== 1'b1 || exp_short !== 1'b1) begin
            n_fail++; $display("FAIL short_flag: got %0b, required 1", short_frame);
        end
        n_cmp++;
        if (fd_count !== 1 || fd_cyc !== exp_fd_cyc) begin
            n_fail++; $display("FAIL short_done: got count=%0d cyc=%0d, required 1 at %0d", fd_count, fd_cyc, exp_fd_cyc);
        end
    endtask

    task automatic test_cfg_err();
        clear_track();
        set_cfg(2, 0, 1, 3);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || cfg_err !== 1'b1 || short_frame !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL cfgerr_step1: got busy=%0b ce=%0b sf=%0b fd=%0b, required 1 1 0 0", busy, cfg_err, short_frame, frame_done);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || frame_done !== 1'b1) begin
            n_fail++; $display("FAIL cfgerr_step2: got busy=%0b fd=%0b, required 0 1", busy, frame_done);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pix_count !== 0 || cfg_err !== 1'b1 || fd_count !== 1) begin
            n_fail++; $display("FAIL cfgerr_after: got pixels=%0d ce=%0b fd=%0d, required 0 1 1", pix_count, cfg_err, fd_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit got;
        clear_track();
        set_cfg(2, 4, 1, 3);
        pulse_start();
        n_cmp++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_cfgerr_clear: got %0b, required 0", cfg_err); end
        exp_capture = 1'b1;
        got = 1'b0;
        fork
            send_frame(8, 6, 7);
            begin
                for (int i = 0; i < 1000 && !got; i++) begin
                    @(negedge clk);
                    #2;
                    if (pix_count >= 5) got = 1'b1;
                end
                if (got) begin
                    reset = 1'b1;
                    exp_capture = 1'b0;
                    #1;
                    n_cmp++;
                    if ({busy, frame_done, short_frame, cfg_err, pix_valid, pix_data, pix_x, pix_y, line_end, frame_end} !== '0) begin
                        n_fail++; $display("FAIL rst_async: got busy=%0b pv=%0b x=%0d y=%0d, required all 0", busy, pix_valid, pix_x, pix_y);
                    end
                    exp_q.delete();
                    @(negedge clk);
                    reset = 1'b0;
                end
            end
        join
        n_cmp++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL rst_wait_pixels: got timeout, required 5 pixels"); end
        n_cmp++;
        if (pix_count !== 5 || fd_count !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_aborted: got pixels=%0d fd=%0d busy=%0b, required 5 0 0", pix_count, fd_count, busy);
        end
        clear_track();
        pulse_start();
        exp_capture = 1'b1;
        send_frame(8, 6, 9);
        wait_idle();
        n_cmp++;
        if (pix_count !== 12 || exp_q.size() != 0 || fd_cyc !== exp_fd_cyc) begin
            n_fail++; $display("FAIL rst_recapture: got %0d fd_cyc=%0d, required 12 at %0d", pix_count, fd_cyc, exp_fd_cyc);
        end
    endtask

    task automatic test_window_edge(input int l, input int w, input int t, input int h);
        clear_track();
        set_cfg(l, w, t, h);
        pulse_start();
        exp_capture = 1'b1;
        send_frame(8, 6, 13);
        wait_idle();
        n_cmp++;
        if (pix_count !== 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL edge_nowrap(%0d,%0d): got %0d pixels, required 0", l, t, pix_count);
        end
        n_cmp++;
        if (short_frame !== 1'b1 || fd_cyc !== exp_fd_cyc) begin
            n_fail++; $display("FAIL edge_done(%0d,%0d): got sf=%0b fd_cyc=%0d, required 1 at %0d", l, t, short_frame, fd_cyc, exp_fd_cyc);
        end
    endtask

    task automatic test_back_to_back();
        clear_track();
        set_cfg(0, 8, 0, 6);
        pulse_start();
        exp_capture = 1'b1;
        send_frame(8, 6, 21);
        wait_idle();
        n_cmp++;
        if (pix_count !== 48 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL full_count: got %0d pending=%0d, required 48 0", pix_count, exp_q.size());
        end
        n_cmp++;
        if (fd_cyc !== exp_fd_cyc || short_frame !== 1'b0) begin
            n_fail++; $display("FAIL full_done: got fd_cyc=%0d sf=%0b, required %0d 0", fd_cyc, short_frame, exp_fd_cyc);
        end
        clear_track();
        set_cfg(5, 3, 4, 2);
        pulse_start();
        exp_capture = 1'b1;
        send_frame(8, 6, 33);
        wait_idle();
        n_cmp++;
        if (pix_count !== 6 || exp_q.size() != 0 || fd_cyc !== exp_fd_cyc) begin
            n_fail++; $display("FAIL corner_roi: got %0d fd_cyc=%0d, required 6 at %0d", pix_count, fd_cyc, exp_fd_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_roi();
        test_midframe_start();
        test_short_frame();
        test_cfg_err();
        test_reset_mid_frame();
        test_window_edge(1020, 8, 0, 3);
        test_window_edge(0, 4, 510, 8);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by time limit, required finish");
        $fatal(1, "timeout");
    end

endmodule
